// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, oversample and frame-size constants,
// and the parity-mode encoding also used by the receiver.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BITS7      = 7;
    localparam int unsigned BITS8      = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    typedef enum logic {
        ParEven = 1'b0,
        ParOdd  = 1'b1
    } parity_e;

    // Index of the final data bit for the selected character length.
    function automatic logic [3:0] last_data_idx(input logic bit8);
        return bit8 ? 4'(BITS8 - 1) : 4'(BITS7 - 1);
    endfunction

endpackage

// File: rtl/uart_tx_bitclk.sv
// Bit-period timer: counts x16 baud ticks and pulses o_bit_done on every 16th tick.
module uart_tx_bitclk
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_baud_en,
    input  logic i_clear,
    output logic o_bit_done
);

    localparam logic [TICK_W-1:0] TickLast = TICK_W'(OVERSAMPLE - 1);

    logic [TICK_W-1:0] r_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick <= '0;
        end else if (i_clear) begin
            r_tick <= '0;
        end else if (i_baud_en) begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    assign o_bit_done = i_baud_en && !i_clear && (r_tick == TickLast);

endmodule

// File: rtl/uart_tx_async.sv
// UART transmitter fed by a holding register (TX_FIFO=0) or an external FIFO (TX_FIFO=1).
// Define UART_TX_TWO_STOP_EN to add the two_stop input selecting a 32-tick stop period.
module uart_tx_async
    import uart_pkg::*;
#(
    parameter int TX_FIFO = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_baud_en,
    input  logic       i_bit8,
    input  logic       i_parity_en,
    input  logic       i_odd_n_even,
`ifdef UART_TX_TWO_STOP_EN
    input  logic       i_two_stop,
`endif
    input  logic       i_wr_en,
    input  logic [7:0] i_data_in,
    input  logic       i_fifo_empty,
    output logic       o_fifo_rd,
    output logic       o_txrdy,
    output logic       o_tx,
    output logic       o_tx_busy
);

    uart_state_e r_state;
    logic [7:0]  r_hold;
    logic [7:0]  r_shift;
    logic [3:0]  r_bitcnt;
    logic        r_txrdy;
    logic        r_fifo_valid;
    logic        r_fifo_rd;
    logic        r_tx;
    logic        r_busy;
    logic        r_par;
    logic        r_bit8;
    logic        r_par_en;
    parity_e     r_par_mode;
    logic        r_stop2;

    logic w_bit_done;
    logic w_cnt_clear;
    logic w_pending;
    logic w_last_bit;
    logic w_load_go;

    assign w_pending   = (TX_FIFO != 0) ? r_fifo_valid : !r_txrdy;
    assign w_cnt_clear = (r_state == StIdle) || (r_state == StLoad);
    assign w_last_bit  = (r_bitcnt == last_data_idx(r_bit8));
    // A pending byte goes straight from the final stop tick into LOAD, so no idle bit appears.
    assign w_load_go   = i_baud_en && w_pending &&
                         ((r_state == StIdle) ||
                          ((r_state == StStop) && w_bit_done && !r_stop2));

    uart_tx_bitclk u_bitclk (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_baud_en  (i_baud_en),
        .i_clear    (w_cnt_clear),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_hold       <= '0;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_txrdy      <= 1'b1;
            r_fifo_valid <= 1'b0;
            r_fifo_rd    <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_par        <= 1'b0;
            r_bit8       <= 1'b1;
            r_par_en     <= 1'b0;
            r_par_mode   <= ParEven;
            r_stop2      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_load_go) r_state <= StLoad;
                end
                StLoad: begin
                    if (i_baud_en) begin
                        r_state <= StStart;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (w_bit_done) begin
                        r_state <= StData;
                        r_tx    <= r_shift[0];
                    end
                end
                StData: begin
                    if (w_bit_done) begin
                        r_par    <= r_par ^ r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (!w_last_bit) begin
                            r_tx <= r_shift[1];
                        end else if (r_par_en) begin
                            r_state <= StParity;
                            r_tx    <= r_par ^ r_shift[0] ^ (r_par_mode == ParOdd);
                        end else begin
                            r_state <= StStop;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (w_bit_done) begin
                        r_state <= StStop;
                        r_tx    <= 1'b1;
                    end
                end
                StStop: begin
                    if (w_bit_done) begin
                        if (r_stop2) begin
                            r_stop2 <= 1'b0;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= w_load_go ? StLoad : StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Frame configuration is frozen here for the whole frame.
            if (w_load_go) begin
                r_shift      <= r_hold;
                r_bitcnt     <= '0;
                r_par        <= 1'b0;
                r_bit8       <= i_bit8;
                r_par_en     <= i_parity_en;
                r_par_mode   <= parity_e'(i_odd_n_even);
`ifdef UART_TX_TWO_STOP_EN
                r_stop2      <= i_two_stop;
`endif
                r_txrdy      <= 1'b1;
                r_fifo_valid <= 1'b0;
            end

            if (TX_FIFO != 0) begin
                r_txrdy   <= !i_fifo_empty;
                r_fifo_rd <= (r_state == StIdle) && !i_fifo_empty && !r_fifo_valid &&
                             !r_fifo_rd;
                if (r_fifo_rd) begin
                    r_hold       <= i_data_in;
                    r_fifo_valid <= 1'b1;
                end
            end else if (i_wr_en) begin
                // A write in the LOAD cycle wins: the new byte stays pending for the next frame.
                r_hold  <= i_data_in;
                r_txrdy <= 1'b0;
            end
        end
    end

    assign o_fifo_rd = r_fifo_rd;
    assign o_txrdy   = r_txrdy;
    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_async.sv
// Directed bench for uart_tx_async: one holding-register instance and one FIFO-mode instance.
module tb_uart_tx_async;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    logic       two_stop = 1'b0;
`endif
    logic       wr_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_empty0 = 1'b1;
    logic       fifo_rd, txrdy, tx, tx_busy;

    logic       f_wr_en = 1'b0;
    logic [7:0] f_data = 8'h00;
    logic       f_empty;
    logic       f_fifo_rd, f_txrdy, f_tx, f_busy;

    logic       mon_sel = 1'b0;
    logic       mon_tx, mon_busy, mon_txrdy;

    int n_checks = 0;
    int n_fail = 0;
    int f_count = 0;
    int f_idx = 0;
    int rd_cycles = 0;
    int rd_pulses = 0;

    uart_tx_async #(.TX_FIFO(0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_baud_en    (baud_en),
        .i_bit8       (bit8),
        .i_parity_en  (parity_en),
        .i_odd_n_even (odd_n_even),
`ifdef UART_TX_TWO_STOP_EN
        .i_two_stop   (two_stop),
`endif
        .i_wr_en      (wr_en),
        .i_data_in    (data_in),
        .i_fifo_empty (fifo_empty0),
        .o_fifo_rd    (fifo_rd),
        .o_txrdy      (txrdy),
        .o_tx         (tx),
        .o_tx_busy    (tx_busy)
    );

    uart_tx_async #(.TX_FIFO(1)) dut_f (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_baud_en    (baud_en),
        .i_bit8       (bit8),
        .i_parity_en  (parity_en),
        .i_odd_n_even (odd_n_even),
`ifdef UART_TX_TWO_STOP_EN
        .i_two_stop   (two_stop),
`endif
        .i_wr_en      (f_wr_en),
        .i_data_in    (f_data),
        .i_fifo_empty (f_empty),
        .o_fifo_rd    (f_fifo_rd),
        .o_txrdy      (f_txrdy),
        .o_tx         (f_tx),
        .o_tx_busy    (f_busy)
    );

    assign mon_tx    = mon_sel ? f_tx : tx;
    assign mon_busy  = mon_sel ? f_busy : tx_busy;
    assign mon_txrdy = mon_sel ? f_txrdy : txrdy;

    initial forever #5 clk = ~clk;

    // One baud_en tick every 4 clocks, changed on the falling edge.
    initial begin
        int bc;
        bc = 0;
        forever begin
            @(negedge clk);
            bc = (bc + 1) % 4;
            baud_en = (bc == 0);
        end
    end

    // External FIFO model: data follows the pop one clock later.
    initial begin
        logic [7:0] fifo_mem [3];
        logic       prev;
        fifo_mem[0] = 8'h11;
        fifo_mem[1] = 8'h80;
        fifo_mem[2] = 8'hC3;
        prev = 1'b0;
        f_empty = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (f_fifo_rd) begin
                rd_cycles++;
                if (!prev) rd_pulses++;
                if (f_idx < 3) begin
                    f_data = fifo_mem[2'(f_idx)];
                    f_idx++;
                end
            end
            prev = f_fifo_rd;
            f_empty = (f_idx >= f_count);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        logic be;
        for (int i = 0; i < n; i++) begin
            do begin
                @(posedge clk);
                be = baud_en;
                #1;
            end while (!be);
        end
    endtask

    task automatic write0(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        data_in = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Samples each bit slot at its 8th tick; bits[k] holds slot k (slot 0 = start bit).
    task automatic capture(output logic [15:0] bits, output int ticks, output int gap,
                           output logic rdy);
        logic       be;
        logic [3:0] slot;
        int         n;
        bits = '0;
        ticks = 0;
        gap = 0;
        n = 0;
        rdy = 1'b0;
        while (mon_tx !== 1'b0 && n < 4000) begin
            @(posedge clk);
            be = baud_en;
            #1;
            n++;
            if (be) gap++;
        end
        check("start_bit_seen", 32'(mon_tx), 0);
        if (mon_tx !== 1'b0) return;
        rdy = mon_txrdy;
        while (ticks < 400) begin
            @(posedge clk);
            be = baud_en;
            #1;
            if (be) begin
                ticks++;
                if ((ticks % 16 == 8) && (ticks < 256)) begin
                    slot = 4'(ticks / 16);
                    bits[slot] = mon_tx;
                end
                if (!mon_busy) break;
            end
        end
    endtask

    initial begin
        logic [15:0] bits;
        int          ticks;
        int          gap;
        int          bad;
        logic        rdy;

        @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 1);
        check("rst_txrdy", 32'(txrdy), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_fifo_rd", 32'(fifo_rd), 0);
        check("rst_f_tx", 32'(f_tx), 1);
        check("rst_f_txrdy", 32'(f_txrdy), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("f_txrdy_empty", 32'(f_txrdy), 0);

        // 8N1, 0xA5
        write0(8'hA5);
        check("a5_txrdy_low", 32'(txrdy), 0);
        capture(bits, ticks, gap, rdy);
        check("a5_bits", 32'(bits), 32'h34A);
        check("a5_ticks", 32'(ticks), 160);
        check("a5_txrdy_at_load", 32'(rdy), 1);

        // 8E1 and 8O1, 0x55
        parity_en = 1'b1;
        odd_n_even = 1'b0;
        write0(8'h55);
        capture(bits, ticks, gap, rdy);
        check("55_even_bits", 32'(bits), 32'h4AA);
        check("55_even_ticks", 32'(ticks), 176);
        odd_n_even = 1'b1;
        write0(8'h55);
        capture(bits, ticks, gap, rdy);
        check("55_odd_bits", 32'(bits), 32'h6AA);
        check("55_odd_ticks", 32'(ticks), 176);

        // 7N1, 0xFF; bit8 raised mid-frame must not lengthen this frame
        parity_en = 1'b0;
        bit8 = 1'b0;
        write0(8'hFF);
        fork
            capture(bits, ticks, gap, rdy);
            begin
                wait_ticks(40);
                bit8 = 1'b1;
            end
        join
        check("ff7_bits", 32'(bits), 32'h1FE);
        check("ff7_ticks", 32'(ticks), 144);

        // Back-to-back: 0x02 written during DATA of 0x01
        write0(8'h01);
        fork
            capture(bits, ticks, gap, rdy);
            begin
                wait_ticks(60);
                write0(8'h02);
            end
        join
        check("b2b1_bits", 32'(bits), 32'h202);
        check("b2b1_ticks", 32'(ticks), 160);
        capture(bits, ticks, gap, rdy);
        check("b2b2_gap", 32'(gap), 1);
        check("b2b2_bits", 32'(bits), 32'h204);
        check("b2b2_ticks", 32'(ticks), 160);
        check("b2b2_txrdy", 32'(rdy), 1);

        // Reset in the middle of DATA with a second byte pending
        write0(8'h00);
        wait_ticks(60);
        check("rst_mid_busy_pre", 32'(tx_busy), 1);
        check("rst_mid_tx_pre", 32'(tx), 0);
        write0(8'h33);
        check("rst_mid_pending", 32'(txrdy), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", 32'(tx), 1);
        check("rst_mid_txrdy", 32'(txrdy), 1);
        check("rst_mid_busy", 32'(tx_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 250; i++) begin
            wait_ticks(1);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("rst_mid_no_frame", 32'(bad), 0);

        // FIFO mode: three queued bytes, wr_en pulses ignored
        mon_sel = 1'b1;
        f_count = 3;
        repeat (3) @(negedge clk);
        check("f_txrdy_data", 32'(f_txrdy), 1);
        fork
            begin
                logic [15:0] fb;
                int          ft;
                int          fg;
                logic        fr;
                capture(fb, ft, fg, fr);
                check("f0_bits", 32'(fb), 32'h222);
                check("f0_ticks", 32'(ft), 160);
                capture(fb, ft, fg, fr);
                check("f1_bits", 32'(fb), 32'h300);
                capture(fb, ft, fg, fr);
                check("f2_bits", 32'(fb), 32'h386);
                check("f2_ticks", 32'(ft), 160);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    wait_ticks(70);
                    @(negedge clk);
                    f_wr_en = 1'b1;
                    @(negedge clk);
                    f_wr_en = 1'b0;
                end
            end
        join
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            wait_ticks(1);
            if (f_tx !== 1'b1 || f_busy !== 1'b0) bad++;
        end
        check("f_no_extra_frame", 32'(bad), 0);
        check("f_rd_pulses", 32'(rd_pulses), 3);
        check("f_rd_cycles", 32'(rd_cycles), 3);
        check("f_txrdy_drained", 32'(f_txrdy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
